// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
//   UART transmit framer. Each frame is a start bit, 5..MAX_DATA_BITS data
//   bits sent LSB first, an optional even/odd parity bit, and 1 or 2 stop
//   bits. Bytes arrive over a valid/ready handshake into a one-entry holding
//   register. That register is loaded straight into a new frame at the end of
//   the last stop bit, so frames can run back to back with no idle gap.
//
// Ports
//   i_clock          system clock, rising edge
//   i_reset_n        asynchronous active-low reset
//   i_tx_data        payload; bits at or above the frame length are ignored
//   i_tx_valid       i_tx_data valid
//   o_tx_ready       holding register empty (transfer on valid & ready)
//   i_cfg_data_bits  data bits per frame; out-of-range clamps to MAX_DATA_BITS
//   i_cfg_parity     00/11 none, 01 even, 10 odd
//   i_cfg_two_stop   1 = two stop bits
//   o_tx_bits        serial line, idle high
//   o_tx_busy        frame in progress or holding register full
//   o_frame_done     one-cycle pulse during the last cycle of the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_framer #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int MAX_DATA_BITS = 9
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic [MAX_DATA_BITS-1:0] i_tx_data,
  input  logic                     i_tx_valid,
  output logic                     o_tx_ready,
  input  logic [3:0]               i_cfg_data_bits,
  input  logic [1:0]               i_cfg_parity,
  input  logic                     i_cfg_two_stop,
  output logic                     o_tx_bits,
  output logic                     o_tx_busy,
  output logic                     o_frame_done
);

  localparam int             TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  TIMER_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     MAX_BITS  = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                   r_state,        w_state_next;
  logic [TW-1:0]            r_timer,        w_timer_next;
  logic [3:0]               r_bit_cnt,      w_bit_cnt_next;
  logic [MAX_DATA_BITS-1:0] r_shift,        w_shift_next;
  logic                     r_par,          w_par_next;
  logic [3:0]               r_cfg_bits,     w_cfg_bits_next;
  logic                     r_cfg_par_en,   w_cfg_par_en_next;
  logic                     r_cfg_odd,      w_cfg_odd_next;
  logic                     r_cfg_two_stop, w_cfg_two_stop_next;
  logic                     r_hold_full,    w_hold_full_next;
  logic [MAX_DATA_BITS-1:0] r_hold_data,    w_hold_data_next;

  logic       w_tick;
  logic       w_last_stop;
  logic       w_load;
  logic [3:0] w_bits_clamped;

  assign w_tick      = (r_timer == TIMER_MAX);
  // Stop-bit counter runs 0 (one stop bit) or 0..1 (two stop bits).
  assign w_last_stop = (r_bit_cnt == {3'b000, r_cfg_two_stop});

  assign w_bits_clamped = ((i_cfg_data_bits < 4'd5) || (i_cfg_data_bits > MAX_BITS))
                          ? MAX_BITS : i_cfg_data_bits;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next        = r_state;
    w_bit_cnt_next      = r_bit_cnt;
    w_shift_next        = r_shift;
    w_par_next          = r_par;
    w_cfg_bits_next     = r_cfg_bits;
    w_cfg_par_en_next   = r_cfg_par_en;
    w_cfg_odd_next      = r_cfg_odd;
    w_cfg_two_stop_next = r_cfg_two_stop;
    w_hold_full_next    = r_hold_full;
    w_hold_data_next    = r_hold_data;
    w_load              = 1'b0;

    // Bit timer idles at zero and wraps on every bit boundary otherwise.
    w_timer_next = ((r_state == S_IDLE) || w_tick) ? '0 : r_timer + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_load = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_next   = S_DATA;
          w_bit_cnt_next = 4'd0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_par_next   = r_par ^ r_shift[0];
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == r_cfg_bits - 4'd1) begin
            w_bit_cnt_next = 4'd0;
            w_state_next   = r_cfg_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_next   = S_STOP;
          w_bit_cnt_next = 4'd0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_last_stop) begin
            // A waiting byte goes straight into a new start bit.
            if (r_hold_full) begin
              w_load = 1'b1;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Frame load: configuration is captured here so later changes on the
    // cfg inputs cannot disturb the frame in flight.
    if (w_load) begin
      w_state_next        = S_START;
      w_shift_next        = r_hold_data;
      w_par_next          = 1'b0;
      w_bit_cnt_next      = 4'd0;
      w_cfg_bits_next     = w_bits_clamped;
      w_cfg_par_en_next   = (i_cfg_parity == 2'b01) || (i_cfg_parity == 2'b10);
      w_cfg_odd_next      = (i_cfg_parity == 2'b10);
      w_cfg_two_stop_next = i_cfg_two_stop;
    end

    // Loading needs a full register and accepting needs an empty one, so the
    // two can never happen on the same edge.
    if (w_load) begin
      w_hold_full_next = 1'b0;
    end else if (i_tx_valid && !r_hold_full) begin
      w_hold_full_next = 1'b1;
      w_hold_data_next = i_tx_data;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_bit_cnt      <= 4'd0;
      r_shift        <= '0;
      r_par          <= 1'b0;
      r_cfg_bits     <= MAX_BITS;
      r_cfg_par_en   <= 1'b0;
      r_cfg_odd      <= 1'b0;
      r_cfg_two_stop <= 1'b0;
      r_hold_full    <= 1'b0;
      r_hold_data    <= '0;
    end else begin
      r_state        <= w_state_next;
      r_timer        <= w_timer_next;
      r_bit_cnt      <= w_bit_cnt_next;
      r_shift        <= w_shift_next;
      r_par          <= w_par_next;
      r_cfg_bits     <= w_cfg_bits_next;
      r_cfg_par_en   <= w_cfg_par_en_next;
      r_cfg_odd      <= w_cfg_odd_next;
      r_cfg_two_stop <= w_cfg_two_stop_next;
      r_hold_full    <= w_hold_full_next;
      r_hold_data    <= w_hold_data_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so reset drives the line
  // high immediately and there is no path from i_tx_valid to any output.
  // -------------------------------------------------------------------------
  always_comb begin
    o_tx_bits = 1'b1;
    case (r_state)
      S_START:  o_tx_bits = 1'b0;
      S_DATA:   o_tx_bits = r_shift[0];
      S_PARITY: o_tx_bits = r_par ^ r_cfg_odd;
      default:  o_tx_bits = 1'b1;
    endcase
  end

  assign o_frame_done = (r_state == S_STOP) && w_tick && w_last_stop;
  assign o_tx_ready   = ~r_hold_full;
  assign o_tx_busy    = (r_state != S_IDLE) || r_hold_full;

endmodule

// File: tb/tb_uart_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_framer
//   Self-checking bench for uart_tx_framer with CLKS_PER_BIT = 4. A frame-level
//   model turns each accepted word into a list of line bits, then expands that
//   list in time. Every cycle the DUT outputs are compared to the model.
//   Directed frames pin the model to hand-worked bit patterns and timings;
//   randomized traffic then runs against the model.
// ---------------------------------------------------------------------------
module tb_uart_tx_framer;

  localparam int CPB  = 4;
  localparam int MAXB = 9;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic [MAXB-1:0] tx_data  = '0;
  logic            tx_valid = 1'b0;
  logic [3:0]      cfg_bits = 4'd8;
  logic [1:0]      cfg_par  = 2'b00;
  logic            cfg_two  = 1'b0;
  logic            o_tx_ready, o_tx_bits, o_tx_busy, o_frame_done;

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .MAX_DATA_BITS(MAXB)) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_tx_data       (tx_data),
    .i_tx_valid      (tx_valid),
    .o_tx_ready      (o_tx_ready),
    .i_cfg_data_bits (cfg_bits),
    .i_cfg_parity    (cfg_par),
    .i_cfg_two_stop  (cfg_two),
    .o_tx_bits       (o_tx_bits),
    .o_tx_busy       (o_tx_busy),
    .o_frame_done    (o_frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
  endtask

  // Frame builder: list of line bits for one frame, bit 0 = start bit.
  function automatic void build(input logic [MAXB-1:0] d, input logic [3:0] nb,
                                input logic [1:0] par, input logic two,
                                output logic [15:0] bits, output int len);
    int   n;
    logic p;
    n    = (nb < 4'd5 || nb > 4'd9) ? 9 : int'(nb);
    bits = '1;
    bits[0] = 1'b0;
    p    = 1'b0;
    for (int i = 0; i < n; i++) begin
      bits[1+i] = d[i];
      p = p ^ d[i];
    end
    len = 1 + n;
    if (par == 2'b01 || par == 2'b10) begin
      bits[len] = p ^ (par == 2'b10);
      len++;
    end
    len += two ? 2 : 1;
  endfunction

  // ---------------- behavioural model ----------------
  int              cyc = 0;          // number of active clock edges seen
  logic            m_hold_full = 1'b0;
  logic [MAXB-1:0] m_hold_data = '0;
  logic [15:0]     m_bits = '1;
  int              m_len = 0, m_start = 0, m_end = 0, m_last_xfer = 0;
  logic            m_exp_tx = 1'b1, m_exp_done = 1'b0, m_exp_ready = 1'b1, m_exp_busy = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_hold_full = 1'b0;
        m_end       = cyc;
        m_exp_tx    = 1'b1;
        m_exp_done  = 1'b0;
        m_exp_ready = 1'b1;
        m_exp_busy  = 1'b0;
      end else begin
        logic old_full, active;
        cyc++;
        old_full = m_hold_full;
        if (old_full && cyc >= m_end) begin
          build(m_hold_data, cfg_bits, cfg_par, cfg_two, m_bits, m_len);
          m_start     = cyc;
          m_end       = cyc + m_len * CPB;
          m_hold_full = 1'b0;
        end
        if (tx_valid && !old_full) begin
          m_hold_full = 1'b1;
          m_hold_data = tx_data;
          m_last_xfer = cyc;
        end
        active      = (cyc < m_end);
        m_exp_tx    = active ? m_bits[(cyc - m_start) / CPB] : 1'b1;
        m_exp_done  = active && (cyc == m_end - 1);
        m_exp_ready = !m_hold_full;
        m_exp_busy  = active || m_hold_full;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int done_edges[$];

  initial begin
    forever begin
      @(negedge clk);
      chk("tx_bits",    32'(o_tx_bits),    32'(m_exp_tx));
      chk("frame_done", 32'(o_frame_done), 32'(m_exp_done));
      chk("tx_ready",   32'(o_tx_ready),   32'(m_exp_ready));
      chk("tx_busy",    32'(o_tx_busy),    32'(m_exp_busy));
      if (o_frame_done) done_edges.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [MAXB-1:0] d, input logic [3:0] nb,
                      input logic [1:0] par, input logic two);
    int n;
    @(negedge clk);
    tx_data  = d;
    cfg_bits = nb;
    cfg_par  = par;
    cfg_two  = two;
    tx_valid = 1'b1;
    n = 0;
    while (!o_tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 32'(n >= 500), 32'd0);
    @(negedge clk);
    tx_valid = 1'b0;
    $display("sent data=%03h bits=%0d parity=%0d two_stop=%0d at edge %0d",
             d, nb, par, two, m_last_xfer);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (o_tx_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n >= 500), 32'd0);
  endtask

  function automatic int first_done();
    return (done_edges.size() > 0) ? done_edges[0] : -1;
  endfunction

  function automatic int done_gap();
    return (done_edges.size() > 1) ? done_edges[1] - done_edges[0] : -1;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] b;
    int          l;

    // Model sanity against hand-worked frames.
    build(9'h0A5, 4'd8, 2'b00, 1'b0, b, l);
    chk("model_8N1_bits", 32'(b[9:0]), 32'b1101001010);
    chk("model_8N1_len",  32'(l), 32'd10);
    build(9'h003, 4'd7, 2'b01, 1'b0, b, l);
    chk("model_7E1_bits", 32'(b[9:0]), 32'b1000000110);
    build(9'h003, 4'd7, 2'b10, 1'b0, b, l);
    chk("model_7O1_bits", 32'(b[9:0]), 32'b1100000110);
    build(9'h1FF, 4'd9, 2'b10, 1'b1, b, l);
    chk("model_9O2_bits", 32'(b[12:0]), 32'b1101111111110);
    chk("model_9O2_len",  32'(l), 32'd13);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_tx_bits", 32'(o_tx_bits),  32'd1);
    chk("reset_ready",   32'(o_tx_ready), 32'd1);
    chk("reset_busy",    32'(o_tx_busy),  32'd0);

    // 1: 8N1 0x0A5, frame_done exactly once, 40 cycles after the transfer.
    done_edges.delete();
    send(9'h0A5, 4'd8, 2'b00, 1'b0);
    wait_idle();
    chk("t1_done_count", 32'(done_edges.size()), 32'd1);
    chk("t1_done_cycle", 32'(first_done() - m_last_xfer), 32'd40);

    // 2: 7E1 and 7O1 of 0x03, 10 bit periods each.
    done_edges.delete();
    send(9'h003, 4'd7, 2'b01, 1'b0);
    wait_idle();
    chk("t2_7E1_len", 32'(first_done() - m_last_xfer), 32'd40);
    done_edges.delete();
    send(9'h003, 4'd7, 2'b10, 1'b0);
    wait_idle();
    chk("t2_7O1_len", 32'(first_done() - m_last_xfer), 32'd40);

    // 3: 9O2 of 0x1FF, 13 bit periods.
    done_edges.delete();
    send(9'h1FF, 4'd9, 2'b10, 1'b1);
    wait_idle();
    chk("t3_9O2_len", 32'(first_done() - m_last_xfer), 32'd52);

    // 4: back to back 8N1 frames, no idle gap.
    done_edges.delete();
    send(9'h055, 4'd8, 2'b00, 1'b0);
    send(9'h0C3, 4'd8, 2'b00, 1'b0);
    wait_idle();
    chk("t4_done_count", 32'(done_edges.size()), 32'd2);
    chk("t4_done_gap",   32'(done_gap()), 32'd40);

    // 5: asynchronous reset in the middle of DATA while the line is low.
    send(9'h000, 4'd8, 2'b00, 1'b0);
    repeat (8) @(negedge clk);
    chk("t5_pre_reset_tx", 32'(o_tx_bits), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_reset_tx",    32'(o_tx_bits),  32'd1);
    chk("t5_reset_ready", 32'(o_tx_ready), 32'd1);
    chk("t5_reset_busy",  32'(o_tx_busy),  32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    done_edges.delete();
    send(9'h0E7, 4'd8, 2'b00, 1'b0);
    wait_idle();
    chk("t5_after_len", 32'(first_done() - m_last_xfer), 32'd40);

    // 6: config changes mid-frame only apply to the next frame (5E2 = 9 bits).
    done_edges.delete();
    send(9'h05A, 4'd8, 2'b00, 1'b0);
    send(9'h013, 4'd5, 2'b01, 1'b1);
    wait_idle();
    chk("t6_done_count", 32'(done_edges.size()), 32'd2);
    chk("t6_done_gap",   32'(done_gap()), 32'd36);

    // Randomized traffic, including out-of-range lengths and valid blips.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        tx_data  = MAXB'($urandom);
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
      send(MAXB'($urandom), 4'($urandom_range(3, 15)), 2'($urandom), 1'($urandom));
      for (int w = $urandom_range(0, 60); w > 0; w--) begin
        @(negedge clk);
        if ($urandom_range(0, 15) == 0) begin
          cfg_bits = 4'($urandom);
          cfg_par  = 2'($urandom);
          cfg_two  = 1'($urandom);
        end
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
